// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES-128 encryption datapath.
// Steps the round index 0..NUM_ROUNDS and drives the datapath load, bypass and handoff controls.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       key_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       init_round,
    output logic       state_en,
    output logic [3:0] count,
    output logic       mix_bypass,
    output logic       out_valid,
    output logic       busy
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
    localparam logic [3:0] PEN  = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       accept;

    // key_valid only matters here; once a block is in flight the key store owns stability
    assign accept = (state == IDLE) && in_valid && key_valid && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ROUND;
                        cnt   <= 4'd1;
                    end else begin
                        cnt   <= 4'd0;
                    end
                end
                ROUND: begin
                    cnt <= cnt + 4'd1;
                    if (cnt >= PEN)
                        state <= FINAL;
                end
                FINAL: begin
                    state <= DONE;
                    cnt   <= LAST;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Outputs are forced low while rst is held so nothing leaks out before state settles
    always_comb begin
        in_ready   = 1'b0;
        init_round = 1'b0;
        state_en   = 1'b0;
        count      = 4'd0;
        mix_bypass = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        if (!rst) begin
            in_ready   = (state == IDLE) && key_valid;
            init_round = accept;
            state_en   = accept || (state == ROUND) || (state == FINAL);
            count      = cnt;
            mix_bypass = (state == FINAL);
            out_valid  = (state == DONE);
            busy       = (state != IDLE);
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: drives a behavioural AES-128 round datapath from the controller
// and checks cycle-by-cycle control outputs plus the resulting ciphertext.
module tb_aes_round_ctrl;

    localparam int NR = 10;

    logic       clk = 1'b0;
    logic       rst, in_valid, key_valid, out_ready;
    logic       in_ready, init_round, state_en, mix_bypass, out_valid, busy;
    logic [3:0] count;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NUM_ROUNDS(NR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .key_valid(key_valid),
        .out_ready(out_ready), .in_ready(in_ready), .init_round(init_round),
        .state_en(state_en), .count(count), .mix_bypass(mix_bypass),
        .out_valid(out_valid), .busy(busy)
    );

    // ---------------- behavioural AES datapath ----------------
    logic [7:0]   sb [256];
    logic [127:0] rk [16];
    logic [127:0] pt, st;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv, r, s;
        inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        r = inv;
        s = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic mix);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   x0, x1, x2, x3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r+4*c] = a[r+4*((c+r)%4)];
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
                b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
                b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
                b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
                b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    always @(posedge clk)
        if (state_en)
            st <= init_round ? (pt ^ rk[count]) : (enc_round(st, !mix_bypass) ^ rk[count]);

    // ---------------- checking ----------------
    int           nchk = 0;
    int           errs = 0;
    logic [127:0] sbq [$];

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
        int           gate;
    } vec_t;
    vec_t tbl [3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // {count, state_en, mix_bypass, init_round, in_ready, busy, out_valid}
    function automatic logic [9:0] status();
        return {count, state_en, mix_bypass, init_round, in_ready, busy, out_valid};
    endfunction

    function automatic logic [9:0] mk(input int c, input logic se, input logic mb,
                                      input logic ir, input logic rdy, input logic bz,
                                      input logic ov);
        return {4'(c), se, mb, ir, rdy, bz, ov};
    endfunction

    task automatic cyc_drive(input logic r, input logic iv, input logic kv, input logic orr);
        @(negedge clk);
        rst = r; in_valid = iv; key_valid = kv; out_ready = orr;
        #1;
    endtask

    task automatic handoff(input string nm);
        if (sbq.size() == 0) chk({nm, " scoreboard empty"}, 128'd1, 128'd0);
        else chk({nm, " ciphertext"}, st, sbq.pop_front());
    endtask

    task automatic run_block(input int idx);
        expand(tbl[idx].key);
        pt = tbl[idx].pt;
        for (int g = 0; g < tbl[idx].gate; g++) begin
            cyc_drive(1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("b%0d key gate %0d", idx, g), status(), mk(0, 0, 0, 0, 0, 0, 0));
        end
        cyc_drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk($sformatf("b%0d accept", idx), status(), mk(0, 1, 0, 1, 1, 0, 0));
        if (init_round) sbq.push_back(tbl[idx].ct);
        for (int k = 1; k < NR; k++) begin
            cyc_drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            chk($sformatf("b%0d round %0d", idx, k), status(), mk(k, 1, 0, 0, 0, 1, 0));
        end
        cyc_drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk($sformatf("b%0d final", idx), status(), mk(NR, 1, 1, 0, 0, 1, 0));
        for (int h = 0; h < tbl[idx].hold; h++) begin
            cyc_drive(1'b0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("b%0d hold %0d", idx, h), status(), mk(NR, 0, 0, 0, 0, 1, 1));
        end
        cyc_drive(1'b0, 1'b1, 1'b1, 1'b1);
        chk($sformatf("b%0d done", idx), status(), mk(NR, 0, 0, 0, 0, 1, 1));
        handoff($sformatf("b%0d", idx));
        cyc_drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk($sformatf("b%0d back idle", idx), status(), mk(0, 0, 0, 0, 1, 0, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errs);
        $fatal(1, "timeout");
    end

    initial begin
        int  a0, a1, outs;
        bit  seen5, ov_seen;

        tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0};
        tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                   128'h3925841d02dc09fbdc118597196a0b32, 5, 4};
        tbl[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 0};

        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        rst = 1'b1; in_valid = 1'b1; key_valid = 1'b1; out_ready = 1'b0;
        pt = '0;

        // reset held two cycles with a block offered
        for (int i = 0; i < 2; i++) begin
            cyc_drive(1'b1, 1'b1, 1'b1, 1'b0);
            chk($sformatf("reset cycle %0d", i), status(), mk(0, 0, 0, 0, 0, 0, 0));
        end
        cyc_drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("after reset", status(), mk(0, 0, 0, 0, 1, 0, 0));

        run_block(0);
        run_block(1);
        run_block(2);

        // back-to-back with in_valid held and out_ready high
        expand(tbl[0].key);
        pt = tbl[0].pt;
        a0 = -1; a1 = -1; outs = 0;
        for (int c = 0; c < 60; c++) begin
            cyc_drive(1'b0, a1 < 0, 1'b1, 1'b1);
            if (busy && init_round) chk("b2b accept while busy", 128'd1, 128'd0);
            if (init_round) begin
                sbq.push_back(tbl[0].ct);
                if (a0 < 0) a0 = c; else a1 = c;
            end
            if (out_valid) begin
                outs++;
                handoff("b2b");
            end
            if (a1 >= 0 && c > a1 + NR + 1) break;
        end
        chk("b2b second accept seen", 128'(a1 >= 0), 128'd1);
        chk("b2b accept spacing", 128'(a1 - a0), 128'(NR + 2));
        chk("b2b outputs", 128'(outs), 128'd2);
        chk("b2b scoreboard drained", 128'(sbq.size()), 128'd0);

        // reset in the middle of a block
        expand(tbl[1].key);
        pt = tbl[1].pt;
        cyc_drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid accept", status(), mk(0, 1, 0, 1, 1, 0, 0));
        seen5 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc_drive(1'b0, 1'b0, 1'b1, 1'b0);
            if (count == 4'd5) begin
                seen5 = 1'b1;
                break;
            end
        end
        chk("mid reached count 5", 128'(seen5), 128'd1);
        rst = 1'b1;
        sbq.delete();
        cyc_drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mid after reset", status(), mk(0, 0, 0, 0, 1, 0, 0));
        ov_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc_drive(1'b0, 1'b0, 1'b1, 1'b1);
            if (out_valid || busy) ov_seen = 1'b1;
        end
        chk("mid no out_valid", 128'(ov_seen), 128'd0);
        run_block(0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for the iterative AES-128 encryption datapath. It accepts one block at a time, steps the 4-bit round index that selects the round key in the key-addition stage (round 0 through 10), and drives the enables and bypass controls for the SubBytes/ShiftRows/MixColumns/AddRoundKey round loop. It holds the finished ciphertext valid until the consumer accepts it. It sits between the block input interface, the expanded-key store and the round-state register.

## Interface
Parameters:
- NUM_ROUNDS, 10: index of the final round. Legal range 2..15, because it must fit the 4-bit count.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  plaintext block present on the datapath input
- key_valid  input  1  expanded round keys 0..NUM_ROUNDS are stable and usable
- out_ready  input  1  consumer accepts the ciphertext this cycle
- in_ready  output  1  controller can accept a block this cycle
- init_round  output  1  datapath selects plaintext and bypasses Sub/Shift/Mix (round 0: key addition only)
- state_en  output  1  round-state register loads the datapath result at the end of this cycle
- count  output  4  round index to the key-addition stage, 0..NUM_ROUNDS
- mix_bypass  output  1  MixColumns bypassed (final round)
- out_valid  output  1  round-state register holds the finished ciphertext
- busy  output  1  a block has been accepted and not yet delivered

## Operation
- States: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready = key_valid; count = 0.
  - Accept occurs when in_valid & in_ready. In the accept cycle, init_round=1 and state_en=1, so the state register captures plaintext XOR key0.
  - The round counter is then set to 1 and the FSM moves to ROUND.
  - If in_valid=1 and key_valid=0, nothing is accepted and the FSM stays in IDLE.
- ROUND:
  - count = current round, 1..NUM_ROUNDS-1; state_en=1; mix_bypass=0; init_round=0.
  - The counter increments each cycle.
  - When count = NUM_ROUNDS-1, the next state is FINAL.
- FINAL:
  - count = NUM_ROUNDS; state_en=1; mix_bypass=1.
  - The next state is DONE.
- DONE:
  - out_valid=1; state_en=0; count held at NUM_ROUNDS; in_ready=0.
  - out_valid stays high until out_ready=1. In that cycle the FSM returns to IDLE and count returns to 0.
  - The next block cannot be accepted in the same cycle as the handoff; the earliest accept is the following cycle.
- busy = 1 in ROUND, FINAL and DONE; 0 in IDLE.
- key_valid is sampled only at accept. If key_valid drops mid-block, the controller ignores it and the key store must keep the keys stable.
- in_valid is ignored outside IDLE.
- The counter never exceeds NUM_ROUNDS and never wraps. Any unreachable state encoding returns to IDLE on the next cycle.

## Timing
- Reset (rst=1 at a rising edge): FSM=IDLE; count=0; in_ready, init_round, state_en, mix_bypass, out_valid and busy all 0 on the following cycle.
- in_ready becomes key_valid from the first non-reset cycle.
- Reset mid-block aborts the block: no out_valid pulse, and the partial state is discarded.
- All outputs are decoded from the FSM state and the counter register, except:
  - in_ready and the IDLE-cycle init_round/state_en also depend on in_valid and key_valid;
  - the DONE to IDLE transition also depends on out_ready.
- Latency: accept in cycle T gives ROUND in T+1..T+NUM_ROUNDS-1, FINAL in T+NUM_ROUNDS, and out_valid in T+NUM_ROUNDS+1 (cycle T+11 at default).
- Throughput: one block per NUM_ROUNDS+2 cycles when out_ready is held high.
- count sequence at default: 0 (accept), 1..9, 10 (FINAL), 10 held in DONE.

## Test plan
- Reset: assert rst for 2 cycles while in_valid=1 and key_valid=1. Required: all outputs 0 during reset; in_ready=1 on the first cycle after reset.
- Single block, integrated with the datapath: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, out_ready=1. Required:
  - count sequence 0,1,…,10;
  - mix_bypass=1 only when count=10;
  - out_valid exactly 11 cycles after accept;
  - ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises. Required: out_valid and count=10 held, state_en=0, in_ready=0 throughout; return to IDLE in the cycle after out_ready=1.
- Key gating: in_valid=1 with key_valid=0 for 4 cycles, then key_valid=1. Required: in_ready=0 and no accept for those 4 cycles; accept on the first cycle key_valid=1.
- Back-to-back blocks: in_valid held high, out_ready=1. Required: the second accept occurs 12 cycles after the first; in_valid pulses arriving while busy=1 are ignored.
- Mid-block reset: assert rst when count=5. Required: the next cycle shows IDLE with count=0 and out_valid never asserted; a new block then completes normally.
